// File: rtl/pes_sysarray_pkg.sv
// Shared definitions for the output-stationary systolic matmul engine.
package pes_sysarray_pkg;

  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_K_MAX      = 256;

  // Accumulator width that cannot overflow for K_MAX products of DW x DW.
  function automatic int f_acc_width(input int dw, input int kmax);
    return 2 * dw + $clog2(kmax);
  endfunction

  // Width able to hold every k_len value 0..K_MAX.
  function automatic int f_kw(input int kmax);
    return $clog2(kmax + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pes_sysarray_gen_pe.sv
// One MAC processing element: forwards A right and B down, accumulates a*b.
module pes_mac_pe
  import pes_sysarray_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int ACC_W = f_acc_width(DEF_DATA_WIDTH, DEF_K_MAX)
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_signed,
  input  logic [DW-1:0]    i_a,
  input  logic [DW-1:0]    i_b,
  output logic [DW-1:0]    o_a,
  output logic [DW-1:0]    o_b,
  output logic [ACC_W-1:0] o_acc
);

  logic [DW-1:0]    r_a, r_b;
  logic [ACC_W-1:0] r_acc;

  // One extra bit carries the sign (or a zero) so a single signed multiplier
  // serves both modes; the product then sign-extends cleanly to ACC_W.
  logic [DW:0]              w_ax, w_bx;
  logic signed [ACC_W-1:0]  w_axe, w_bxe;
  logic [ACC_W-1:0]         w_prod;

  assign w_ax   = {i_signed & i_a[DW-1], i_a};
  assign w_bx   = {i_signed & i_b[DW-1], i_b};
  assign w_axe  = ACC_W'($signed(w_ax));
  assign w_bxe  = ACC_W'($signed(w_bx));
  assign w_prod = w_axe * w_bxe;

  // Operand pass-through and wrap-around accumulation while the array shifts.
  always_ff @(posedge clk) begin
    if (!srstn || i_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/pes_sysarray_gen.sv
// N x N output-stationary systolic matmul: skewed operand streams in, rows out.
module pes_sysarray_gen
  import pes_sysarray_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_MAX      = DEF_K_MAX,
  parameter int KW         = f_kw(K_MAX),
  parameter int ACC_WIDTH  = f_acc_width(DATA_WIDTH, K_MAX)
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             start,
  input  logic [KW-1:0]                    k_len,
  input  logic                             signed_mode,
  output logic                             busy,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_col,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_row,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]    out_row_idx,
  output logic                             done
);

  localparam int N   = ARRAY_SIZE;
  localparam int DW  = DATA_WIDTH;
  localparam int ACC = ACC_WIDTH;
  localparam int RW  = $clog2(N);
  localparam int FW  = $clog2(2 * N);

  state_t       r_state;
  logic [KW-1:0] r_klen, r_beat;
  logic [FW-1:0] r_flush;
  logic [RW-1:0] r_row;
  logic          r_signed, r_done;

  logic          w_shift, w_clr, w_beat_ok;
  logic [KW-1:0] w_klen;
  logic [N-1:0][DW-1:0] w_a_inj, w_b_inj;
  logic [N-1:0][N:0][DW-1:0] w_ah;   // horizontal A links, column N is the spill-out
  logic [N:0][N-1:0][DW-1:0] w_bv;   // vertical B links, row N is the spill-out
  logic [N-1:0][DW-1:0]      w_unused_a, w_unused_b;
  logic [N-1:0][N-1:0][ACC-1:0] w_acc;

  assign w_shift   = (r_state == LOAD) || (r_state == FLUSH);
  assign w_clr     = (r_state == IDLE) && start;
  assign w_beat_ok = (r_state == LOAD) && in_valid;
  assign w_klen    = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  // Idle LOAD cycles and FLUSH push zeros, so gaps never change the result.
  assign w_a_inj   = w_beat_ok ? a_col : '0;
  assign w_b_inj   = w_beat_ok ? b_row : '0;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign w_ah[0][0] = w_a_inj[0];
      assign w_bv[0][0] = w_b_inj[0];
    end else begin : g_delay
      logic [i-1:0][DW-1:0] r_ska, r_skb;
      // Lane i is delayed i shift cycles so operands meet on the diagonal.
      always_ff @(posedge clk) begin
        if (!srstn || w_clr) begin
          r_ska <= '0;
          r_skb <= '0;
        end else if (w_shift) begin
          r_ska[0] <= w_a_inj[i];
          r_skb[0] <= w_b_inj[i];
          for (int s = 1; s < i; s++) begin
            r_ska[s] <= r_ska[s-1];
            r_skb[s] <= r_skb[s-1];
          end
        end
      end
      assign w_ah[i][0] = r_ska[i-1];
      assign w_bv[0][i] = r_skb[i-1];
    end
    assign w_unused_a[i] = w_ah[i][N];
    assign w_unused_b[i] = w_bv[N][i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      pes_mac_pe #(.DW(DW), .ACC_W(ACC)) u_pe (
        .clk      (clk),
        .srstn    (srstn),
        .i_en     (w_shift),
        .i_clr    (w_clr),
        .i_signed (r_signed),
        .i_a      (w_ah[i][j]),
        .i_b      (w_bv[i][j]),
        .o_a      (w_ah[i][j+1]),
        .o_b      (w_bv[i+1][j]),
        .o_acc    (w_acc[i][j])
      );
    end
  end

  // Job sequencing: latch job, count beats, flush the wavefront, drain rows.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state  <= IDLE;
      r_klen   <= '0;
      r_signed <= 1'b0;
      r_beat   <= '0;
      r_flush  <= '0;
      r_row    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_klen   <= w_klen;
          r_signed <= signed_mode;
          r_beat   <= '0;
          r_flush  <= '0;
          r_row    <= '0;
          r_state  <= (w_klen == '0) ? FLUSH : LOAD;
        end
        LOAD: if (in_valid) begin
          r_beat <= r_beat + KW'(1);
          if (r_beat == r_klen - KW'(1)) r_state <= FLUSH;
        end
        FLUSH: begin
          r_flush <= r_flush + FW'(1);
          if (r_flush == FW'(2 * N - 2)) r_state <= DRAIN;
        end
        DRAIN: if (out_ready) begin
          if (r_row == RW'(N - 1)) begin
            r_row   <= '0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign in_ready    = (r_state == LOAD);
  assign out_valid   = (r_state == DRAIN);
  assign out_row     = w_acc[r_row];
  assign out_row_idx = r_row;
  assign done        = r_done;

endmodule

// File: tb/tb_pes_sysarray_gen.sv
// Directed + randomized bench for pes_sysarray_gen at N=4, DW=8.
module tb_pes_sysarray_gen;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int ACC  = 2 * DW + $clog2(KMAX);

  logic              clk = 1'b0;
  logic              srstn, start, signed_mode, in_valid, out_ready;
  logic [KW-1:0]     k_len;
  logic              busy, in_ready, out_valid, done;
  logic [N*DW-1:0]   a_col, b_row;
  logic [N*ACC-1:0]  out_row;
  logic [$clog2(N)-1:0] out_row_idx;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] Am [N][KMAX];
  logic [DW-1:0] Bm [KMAX][N];

  always #5 clk = ~clk;

  pes_sysarray_gen #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .K_MAX(KMAX)) dut (
    .clk(clk), .srstn(srstn), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .done(done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint ext(input logic [DW-1:0] x, input bit sm);
    if (sm) return longint'($signed(x));
    return longint'({56'd0, x});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_in_ready"}, in_ready, 0);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_out_row"}, out_row, 0);
    check({pfx, "_out_row_idx"}, out_row_idx, 0);
    check({pfx, "_done"}, done, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        Am[i][k] = DW'($urandom);
        Bm[k][i] = DW'($urandom);
      end
  endtask

  // Runs one job; golden rows are plain sums of extended products mod 2^ACC.
  task automatic run_job(input int k, input bit sm, input int vprob,
                         input int hold_row, input int hold_cyc, input bit poke);
    logic [N*ACC-1:0] exp_row [N];
    longint c;
    int cyc, beat, guard;
    bit v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = 0;
        for (int kk = 0; kk < k; kk++) c += ext(Am[i][kk], sm) * ext(Bm[kk][j], sm);
        exp_row[i][j*ACC +: ACC] = c[ACC-1:0];
      end

    start = 1'b1; k_len = KW'(k); signed_mode = sm;
    tick();
    start = 1'b0; k_len = KW'($urandom); signed_mode = ~sm;
    cyc = 1;
    check("busy_after_start", busy, 1);

    beat = 0; guard = 0;
    while (beat < k && guard < 2000) begin
      v = ($urandom_range(99) < vprob);
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = Am[i][beat];
        b_row[i*DW +: DW] = Bm[beat][i];
      end
      in_valid = v;
      tick();
      cyc++; guard++;
      if (v) beat++;
    end
    in_valid = 1'b0;
    a_col = $urandom;
    b_row = $urandom;

    if (poke) begin start = 1'b1; k_len = KW'(5); end
    guard = 0;
    while (!out_valid && guard < 500) begin tick(); cyc++; guard++; end
    start = 1'b0;
    check("out_valid_seen", out_valid, 1);
    if (vprob >= 100) check("latency", cyc, 1 + k + 2 * N - 1);
    check("in_ready_drain", in_ready, 0);

    for (int r = 0; r < N; r++) begin
      if (r == hold_row) begin
        out_ready = 1'b0;
        repeat (hold_cyc) begin
          tick();
          check("hold_valid", out_valid, 1);
          check("hold_idx", out_row_idx, r);
          check("hold_row", out_row, exp_row[r]);
        end
      end
      check("row_valid", out_valid, 1);
      check("row_idx", out_row_idx, r);
      check("row_data", out_row, exp_row[r]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (r < N - 1) check("no_early_done", done, 0);
    end
    check("done_pulse", done, 1);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    tick();
    check("done_clear", done, 0);
  endtask

  initial begin
    srstn = 1'b0; start = 1'b0; k_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
    tick(); tick();
    check_reset_outputs("reset");
    srstn = 1'b1;
    tick();

    // Identity A, B[k][j] = 4k+j: rows come out equal to B.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        Am[i][k] = (i == k) ? 8'd1 : 8'd0;
        Bm[k][i] = DW'(4 * k + i);
      end
    run_job(4, 1'b0, 100, -1, 0, 1'b0);

    // Signed extremes: -128 * -128 * 3 and -1 * 5 * 3.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin Am[i][k] = 8'h80; Bm[k][i] = 8'h80; end
    run_job(3, 1'b1, 100, -1, 0, 1'b0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin Am[i][k] = 8'hFF; Bm[k][i] = 8'h05; end
    run_job(3, 1'b1, 100, -1, 0, 1'b0);

    // Random K=17: no stalls, then input gaps plus an output stall on row 2.
    fill_random();
    run_job(17, 1'b0, 100, -1, 0, 1'b0);
    run_job(17, 1'b0, 50, 2, 3, 1'b0);
    fill_random();
    run_job(17, 1'b1, 50, 1, 2, 1'b0);

    // K=0 with a start poked while busy.
    run_job(0, 1'b0, 100, -1, 0, 1'b1);

    // Abort a job mid-LOAD with reset, then a clean K=2 job.
    fill_random();
    start = 1'b1; k_len = KW'(10); signed_mode = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    repeat (3) begin a_col = $urandom; b_row = $urandom; tick(); end
    srstn = 1'b0; in_valid = 1'b0;
    tick();
    check_reset_outputs("midjob_reset");
    srstn = 1'b1;
    tick();
    fill_random();
    run_job(2, 1'b0, 100, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pes_sysarray_gen.md
Name: pes_sysarray_gen

Overview:
Parametrised output-stationary systolic matrix-multiply engine, N x N processing elements (PEs). It computes C = A x B, where A is N x K and B is K x N. K is chosen at run time.
It replaces fixed 8x8, two-SRAM-word feeding and an externally supplied cycle count with three things: an internal skew network, an internal FSM/counters, and valid/ready streaming on input and output.
It sits between the SRAM read controllers (operand streams) and the post-processing/writeback stage (row-by-row result stream).

Parameters:
ARRAY_SIZE, 8, N: PE rows and columns.
DATA_WIDTH, 8, operand element width.
K_MAX, 256, largest supported inner dimension.
KW, $clog2(K_MAX+1), width of k_len.
ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX), accumulator/result element width (24 at defaults).

Ports:
clk  in  1  clock
srstn  in  1  synchronous active-low reset
start  in  1  begin a job; accepted only in IDLE
k_len  in  KW  inner dimension K; sampled with start
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
busy  out  1  high in every state except IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  high only in LOAD
a_col  in  N*DATA_WIDTH  column k of A; element i = A[i][k] at bits [i*DW +: DW]
b_row  in  N*DATA_WIDTH  row k of B; element j = B[k][j] at bits [j*DW +: DW]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_row  out  N*ACC_WIDTH  C[r][j] at bits [j*ACC_WIDTH +: ACC_WIDTH]
out_row_idx  out  $clog2(N)  row index r
done  out  1  one-cycle pulse after the final row handshake

Behaviour:
- Reset is srstn=0 at a clk edge. It clears the FSM to IDLE and zeroes all accumulators, skew and pipeline registers, and counters. Output reset values: busy=0, in_ready=0, out_valid=0, out_row=0, out_row_idx=0, done=0. Reset mid-job abandons the job with no residual state.
- FSM states:
  - IDLE: start=1 clears all accumulators and latches k_len and signed_mode. Go to LOAD if k_len>0, else to FLUSH.
  - LOAD: a beat is accepted on in_valid&in_ready. If in_valid=0, an all-zero bubble is injected instead. The array shifts every cycle regardless. The beat counter counts accepted beats only. When beat k_len is accepted, go to FLUSH.
  - FLUSH: exactly 2N-1 cycles of zero injection while the array keeps shifting. Then go to DRAIN.
  - DRAIN: present row r = 0..N-1. out_row/out_row_idx must hold stable while out_valid&!out_ready. On the handshake for row N-1, go to IDLE and pulse done for the next cycle.
- Skew: a_col element i is delayed i cycles before entering PE(i,0). b_row element j is delayed j cycles before entering PE(0,j). Operands then propagate right and down one PE per cycle.
- PE(i,j) accumulates acc += a*b each cycle. Products are sign- or zero-extended from 2*DW to ACC_WIDTH according to the latched signed_mode. Accumulation wraps modulo 2^ACC_WIDTH (no saturation); no overflow is possible for K<=K_MAX.
- Bubbles contribute 0, so results are independent of in_valid gaps.
- k_len > K_MAX is clamped to K_MAX.
- start outside IDLE is ignored. k_len and signed_mode changes after start have no effect.
- Shifting is enabled only in LOAD and FLUSH. Accumulators are frozen in DRAIN and IDLE.
- Minimum job latency (no stalls) from start to first out_valid: 1 + K + 2N - 1 cycles.

Decomposition:
- Shared package pes_sysarray_pkg: acc_width/kw helper functions, FSM state enum (IDLE, LOAD, FLUSH, DRAIN), default parameter constants.
- One sub-module, pes_mac_pe: operand pass-through registers (right/down), signed/unsigned multiply, accumulator with synchronous clear and enable.
- The top level instantiates N*N PEs via generate, plus skew shift registers, FSM, counters, and the output mux.

Test Plan:
- N=4, K=4, signed_mode=0, A=identity, B[k][j]=4k+j, no stalls -> rows out = B exactly, out_row_idx 0..3, done once; first out_valid 12 cycles after start.
- N=4, K=3, signed, A all -128, B all -128 -> every C[i][j] = 49152 (0x00C000); A=-1, B=+5 -> every C = -15 (0xFFFFF1).
- Random A and B with K=17 and in_valid randomly low 50% of the time -> results match the golden model, identical to the no-stall run.
- out_ready low for 3 cycles on row 2 -> out_row and out_row_idx=2 stable, no row skipped or duplicated, done after row 3.
- k_len=0 -> all rows zero, done after 2N-1 flush cycles plus N rows; start asserted while busy is ignored.
- srstn pulsed low during LOAD, then a new job with K=2 -> correct result with no contamination from the aborted job.
